// File: rtl/shot_scheduler.sv
// ---------------------------------------------------------------------------
// shot_scheduler
//   Shares the single imager -> encoder -> flash_disk capture pipeline among
//   N_REQ shot requesters using round-robin arbitration. The winning request
//   has its factor_sel and print_date latched. The block then drives shoot for
//   SHOOT_LEN cycles and waits for eof_in. An error, a watchdog expiry or an
//   early eof_in ends the shot as an abort.
//
// Ports
//   clk_in      in   1          encoder clock, rising edge
//   rst_n       in   1          asynchronous active-low reset
//   req         in   N_REQ      level requests, held until granted
//   req_factor  in   2*N_REQ    factor_sel per requester, [2i+1:2i]
//   req_date    in   N_REQ      print_date enable per requester
//   eof_in      in   1          end-of-frame pulse from the flash side
//   err_in      in   1          flash error level
//   grant       out  N_REQ      one-hot accept pulse
//   shoot       out  1          shoot to imager and encoder
//   factor_sel  out  2          factor of the active shot
//   print_date  out  1          date enable of the active shot
//   ready       out  1          high only while idle
//   busy_id     out  3          index of the active requester
//   done        out  N_REQ      one-hot completion pulse
//   abort       out  1          completion was an error or timeout
//   shot_cnt    out  CNT_W      successful shot count, wraps
// ---------------------------------------------------------------------------
module shot_scheduler #(
    parameter int N_REQ     = 4,
    parameter int SHOOT_LEN = 16,
    parameter int TO_W      = 24,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_factor,
    input  logic [N_REQ-1:0]     req_date,
    input  logic                 eof_in,
    input  logic                 err_in,
    output logic [N_REQ-1:0]     grant,
    output logic                 shoot,
    output logic [1:0]           factor_sel,
    output logic                 print_date,
    output logic                 ready,
    output logic [2:0]           busy_id,
    output logic [N_REQ-1:0]     done,
    output logic                 abort,
    output logic [CNT_W-1:0]     shot_cnt
);

    localparam int              SH_W    = (SHOOT_LEN > 1) ? $clog2(SHOOT_LEN) : 1;
    localparam logic [SH_W-1:0] SH_LAST = SH_W'(SHOOT_LEN - 1);
    localparam logic [TO_W-1:0] WD_MAX  = '1;
    // One below the maximum: the shot is aborted on the edge where the
    // watchdog reaches its maximum value.
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]      N4      = 4'(N_REQ);
    localparam logic [N_REQ-1:0] ONE    = N_REQ'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHOOT, ST_BUSY, ST_DONE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         rr_ptr_reg, rr_ptr_next;
    logic [SH_W-1:0]    sh_cnt_reg, sh_cnt_next;
    logic [TO_W-1:0]    wd_reg, wd_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic               shoot_reg, shoot_next;
    logic [1:0]         factor_reg, factor_next;
    logic               date_reg, date_next;
    logic               ready_reg, ready_next;
    logic [2:0]         busy_id_reg, busy_id_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic               abort_reg, abort_next;
    logic [CNT_W-1:0]   shot_cnt_reg, shot_cnt_next;

    // Round-robin pick: rotate the request vector so rr_ptr lands on bit 0,
    // take the lowest set bit, then rotate the offset back.
    logic [N_REQ-1:0]   req_rot;
    logic [2:0]         win_off;
    logic [3:0]         win_sum;
    logic [2:0]         win_id;
    logic               win_valid;
    logic [1:0]         win_factor;
    logic               win_date;

    assign req_rot    = N_REQ'({req, req} >> rr_ptr_reg);
    assign win_valid  = |req;
    assign win_sum    = {1'b0, rr_ptr_reg} + {1'b0, win_off};
    assign win_id     = (win_sum >= N4) ? 3'(win_sum - N4) : win_sum[2:0];
    assign win_factor = 2'(req_factor >> {win_id, 1'b0});
    assign win_date   = 1'(req_date >> win_id);

    always_comb begin
        win_off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                win_off = 3'(j);
            end
        end
    end

    logic shoot_last;
    logic wd_expire;
    assign shoot_last = (sh_cnt_reg == SH_LAST);
    assign wd_expire  = (wd_reg >= WD_LAST);

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            sh_cnt_reg   <= '0;
            wd_reg       <= '0;
            grant_reg    <= '0;
            shoot_reg    <= 1'b0;
            factor_reg   <= '0;
            date_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            busy_id_reg  <= '0;
            done_reg     <= '0;
            abort_reg    <= 1'b0;
            shot_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            sh_cnt_reg   <= sh_cnt_next;
            wd_reg       <= wd_next;
            grant_reg    <= grant_next;
            shoot_reg    <= shoot_next;
            factor_reg   <= factor_next;
            date_reg     <= date_next;
            ready_reg    <= ready_next;
            busy_id_reg  <= busy_id_next;
            done_reg     <= done_next;
            abort_reg    <= abort_next;
            shot_cnt_reg <= shot_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (win_valid) state_next = ST_SHOOT;
            ST_SHOOT: begin
                if (eof_in)          state_next = ST_DONE;
                else if (shoot_last) state_next = ST_BUSY;
            end
            ST_BUSY:  if (eof_in || err_in || wd_expire) state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        rr_ptr_next   = rr_ptr_reg;
        sh_cnt_next   = sh_cnt_reg;
        wd_next       = wd_reg;
        grant_next    = '0;
        shoot_next    = shoot_reg;
        factor_next   = factor_reg;
        date_next     = date_reg;
        ready_next    = ready_reg;
        busy_id_next  = busy_id_reg;
        done_next     = '0;
        abort_next    = 1'b0;
        shot_cnt_next = shot_cnt_reg;

        if (state_reg == ST_SHOOT || state_reg == ST_BUSY) begin
            if (wd_reg != WD_MAX) wd_next = wd_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_next   = ONE << win_id;
                    shoot_next   = 1'b1;
                    ready_next   = 1'b0;
                    busy_id_next = win_id;
                    factor_next  = win_factor;
                    date_next    = win_date;
                    rr_ptr_next  = (win_id == 3'(N_REQ - 1)) ? 3'd0 : win_id + 3'd1;
                    sh_cnt_next  = '0;
                    wd_next      = '0;
                end
            end
            ST_SHOOT: begin
                if (eof_in) begin
                    // Frame end while still shooting is a protocol error.
                    shoot_next = 1'b0;
                    done_next  = ONE << busy_id_reg;
                    abort_next = 1'b1;
                end else if (shoot_last) begin
                    shoot_next = 1'b0;
                end else begin
                    sh_cnt_next = sh_cnt_reg + 1'b1;
                end
            end
            ST_BUSY: begin
                // eof_in takes precedence over a simultaneous error.
                if (eof_in) begin
                    done_next     = ONE << busy_id_reg;
                    shot_cnt_next = shot_cnt_reg + 1'b1;
                end else if (err_in || wd_expire) begin
                    done_next  = ONE << busy_id_reg;
                    abort_next = 1'b1;
                end
            end
            default: begin
                ready_next = 1'b1;
            end
        endcase
    end

    assign grant      = grant_reg;
    assign shoot      = shoot_reg;
    assign factor_sel = factor_reg;
    assign print_date = date_reg;
    assign ready      = ready_reg;
    assign busy_id    = busy_id_reg;
    assign done       = done_reg;
    assign abort      = abort_reg;
    assign shot_cnt   = shot_cnt_reg;

endmodule

// File: tb/tb_shot_scheduler.sv
module tb_shot_scheduler;

    localparam int N_REQ     = 4;
    localparam int SHOOT_LEN = 16;
    localparam int TO_W      = 10;
    localparam int CNT_W     = 4;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [7:0]       req_factor;
    logic [3:0]       req_date;
    logic             eof_in;
    logic             err_in;
    logic [3:0]       grant;
    logic             shoot;
    logic [1:0]       factor_sel;
    logic             print_date;
    logic             ready;
    logic [2:0]       busy_id;
    logic [3:0]       done;
    logic             abort;
    logic [CNT_W-1:0] shot_cnt;

    shot_scheduler #(
        .N_REQ(N_REQ), .SHOOT_LEN(SHOOT_LEN), .TO_W(TO_W), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .req(req), .req_factor(req_factor),
        .req_date(req_date), .eof_in(eof_in), .err_in(err_in), .grant(grant),
        .shoot(shoot), .factor_sel(factor_sel), .print_date(print_date),
        .ready(ready), .busy_id(busy_id), .done(done), .abort(abort),
        .shot_cnt(shot_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: round-robin pointer and successful-shot count.
    int model_rr  = 0;
    int model_cnt = 0;

    // kind: 0 eof in BUSY, 1 err in BUSY, 2 eof+err in BUSY, 3 eof during SHOOT
    typedef struct {
        logic [3:0] r;
        logic [7:0] f;
        logic [3:0] d;
        int         kind;
        int         dly;
        logic [3:0] eg;
        logic [1:0] ef;
        logic       ed;
        logic       ea;
        logic [3:0] ec;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int oh2idx(input logic [3:0] oh);
        int idx = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) idx = i;
        return idx;
    endfunction

    // First set request at or after the pointer, wrapping around.
    function automatic int model_pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            int i = (ptr + k) % N_REQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic run_shot(input logic [3:0] r, input logic [7:0] f, input logic [3:0] d,
                            input int kind, input int dly, input logic [3:0] eg,
                            input logic [1:0] ef, input logic ed, input logic ea,
                            input logic [3:0] ec);
        int  hi;
        bit  extra;
        req = r; req_factor = f; req_date = d;
        tick();
        check("grant", grant, eg);
        check("shoot_on", shoot, 1'b1);
        check("ready_low", ready, 1'b0);
        check("busy_id", busy_id, oh2idx(eg));
        check("factor_sel", factor_sel, ef);
        check("print_date", print_date, ed);
        extra = 0;
        hi = 0;
        while (shoot === 1'b1 && hi < 64) begin
            hi++;
            if (kind == 3 && hi == dly) eof_in = 1'b1;
            req = 4'($urandom_range(0, 15));
            tick();
            eof_in = 1'b0;
            if (grant !== 4'b0) extra = 1;
        end
        check("shoot_len", hi, (kind == 3) ? dly : SHOOT_LEN);
        if (kind != 3) begin
            for (int i = 0; i < dly; i++) begin
                req = 4'($urandom_range(0, 15));
                tick();
                if (grant !== 4'b0 || done !== 4'b0 || abort !== 1'b0) extra = 1;
            end
            eof_in = (kind != 1);
            err_in = (kind != 0);
            req = 4'b0;
            tick();
            eof_in = 1'b0;
            err_in = 1'b0;
        end
        check("done", done, eg);
        check("abort", abort, ea);
        check("shot_cnt", shot_cnt, ec);
        req = 4'b0;
        tick();
        check("ready_back", ready, 1'b1);
        check("done_clear", {abort, done}, 5'b0);
        check("no_extra_grant", extra, 1'b0);
        $display("shot req=%b kind=%0d dly=%0d grant=%b done=%b abort=%b cnt=%0d",
                 r, kind, dly, eg, done, ea, shot_cnt);
    endtask

    initial begin
        // Known-answer sequence starting from reset (rr_ptr=0, shot_cnt=0).
        tbl[0] = '{4'b0100, 8'b0010_0000, 4'b0100, 0, 484, 4'b0100, 2'd2, 1'b1, 1'b0, 4'd1};
        tbl[1] = '{4'b1111, 8'hE4, 4'b1010, 0, 0, 4'b1000, 2'd3, 1'b1, 1'b0, 4'd2};
        tbl[2] = '{4'b1111, 8'hE4, 4'b1010, 0, 5, 4'b0001, 2'd0, 1'b0, 1'b0, 4'd3};
        tbl[3] = '{4'b1111, 8'hE4, 4'b1010, 1, 3, 4'b0010, 2'd1, 1'b1, 1'b1, 4'd3};
        tbl[4] = '{4'b1111, 8'hE4, 4'b1010, 2, 2, 4'b0100, 2'd2, 1'b0, 1'b0, 4'd4};
        tbl[5] = '{4'b1001, 8'hE4, 4'b1010, 3, 5, 4'b1000, 2'd3, 1'b1, 1'b1, 4'd4};
        tbl[6] = '{4'b1001, 8'hE4, 4'b1010, 0, 1, 4'b0001, 2'd0, 1'b0, 1'b0, 4'd5};
        tbl[7] = '{4'b1001, 8'hE4, 4'b1010, 0, 0, 4'b1000, 2'd3, 1'b1, 1'b0, 4'd6};

        rst_n = 1'b0; req = 4'b0; req_factor = 8'h0; req_date = 4'b0;
        eof_in = 1'b0; err_in = 1'b0;
        tick(); tick();
        check("rst_ready", ready, 1'b1);
        check("rst_outputs", {grant, shoot, factor_sel, print_date, busy_id, done, abort, shot_cnt}, 0);
        rst_n = 1'b1;

        // Reset in the middle of a shot drops everything immediately.
        req = 4'b0100; req_factor = 8'hFF; req_date = 4'b1111;
        tick();
        check("pre_rst_grant", grant, 4'b0100);
        req = 4'b0;
        tick(); tick(); tick();
        #1 rst_n = 1'b0;
        #1;
        check("async_shoot", shoot, 1'b0);
        check("async_ready", ready, 1'b1);
        check("async_pulses", {grant, done, abort}, 9'b0);
        tick();
        rst_n = 1'b1;
        req = 4'b0001;
        tick();
        check("post_rst_grant", grant, 4'b0001);
        req = 4'b0;
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        model_rr = 0; model_cnt = 0;
        for (int v = 0; v < 8; v++) begin
            run_shot(tbl[v].r, tbl[v].f, tbl[v].d, tbl[v].kind, tbl[v].dly,
                     tbl[v].eg, tbl[v].ef, tbl[v].ed, tbl[v].ea, tbl[v].ec);
            model_rr  = (oh2idx(tbl[v].eg) + 1) % N_REQ;
            model_cnt = int'(tbl[v].ec);
        end

        // Randomized shots against the reference model; long enough to wrap shot_cnt.
        for (int s = 0; s < 48; s++) begin
            logic [3:0] r;
            logic [7:0] f;
            logic [3:0] d;
            int kind, dly, w;
            logic ea;
            r = 4'($urandom_range(1, 15));
            f = 8'($urandom);
            d = 4'($urandom);
            kind = (s < 20) ? 0 : int'($urandom_range(0, 3));
            dly = (kind == 3) ? int'($urandom_range(1, 15)) : int'($urandom_range(0, 20));
            w = model_pick(r, model_rr);
            ea = (kind == 1 || kind == 3);
            if (!ea) model_cnt = (model_cnt + 1) % (1 << CNT_W);
            model_rr = (w + 1) % N_REQ;
            run_shot(r, f, d, kind, dly, 4'(1 << w), 2'(f >> (2 * w)), d[w], ea, 4'(model_cnt));
        end

        // Watchdog: no eof at all.
        begin
            int w, n;
            w = model_pick(4'b0010, model_rr);
            model_rr = (w + 1) % N_REQ;
            req = 4'b0010;
            tick();
            check("to_grant", grant, 4'(1 << w));
            req = 4'b0;
            n = 0;
            while (abort !== 1'b1 && n < 5000) begin
                tick();
                n++;
            end
            check("to_cycles", n, (1 << TO_W) - 1);
            check("to_done", done, 4'(1 << w));
            check("to_cnt", shot_cnt, 4'(model_cnt));
            tick();
            check("to_ready", ready, 1'b1);
            $display("timeout grant=%b after %0d cycles", 4'(1 << w), n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
